// File: rtl/xbar_rr_sched.sv
// Round-robin transmit scheduler: four requesters share one crossbar write bus, gated by per-destination credits.
// Optional per-requester grant counters are enabled with `define XBAR_SCHED_STATS_EN.
module xbar_rr_sched #(
    parameter int AW_DEV = 2,
    parameter int DW     = 4,
    parameter int DEPTH  = 2,
    parameter int N_DEV  = 1 << AW_DEV
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [3:0]                 validtx_i,
    input  logic [4*AW_DEV-1:0]        adr_i,
    input  logic [4*DW-1:0]            dat_i,
    output logic [3:0]                 acktx_o,
    output logic [N_DEV-1:0]           int_wen_o,
    output logic [DW-1:0]              int_dat_o,
    input  logic [N_DEV-1:0]           credit_ret_i,
    output logic [N_DEV*(DEPTH+1)-1:0] credit_o,
    output logic                       err_o
`ifdef XBAR_SCHED_STATS_EN
    ,
    input  logic                       stats_clr_i,
    output logic [4*8-1:0]             grant_cnt_o
`endif
);

    localparam int CW = DEPTH + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(1 << DEPTH);

    logic [3:0]                ack_q, ack_d;
    logic [N_DEV-1:0]          wen_q, wen_d;
    logic [DW-1:0]             dat_q, dat_d;
    logic [1:0]                ptr_q, ptr_d;
    logic                      err_q, err_d;

    logic [N_DEV-1:0][CW-1:0]  cred_all;
    logic [N_DEV-1:0]          ovf;
    logic [3:0]                elig;
    logic                      win_vld;
    logic [1:0]                win_idx;
    logic [1:0]                scan_idx;
    logic [AW_DEV-1:0]         win_adr;

    // The ack mask keeps a requester from being granted twice while it reacts to its ack.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_elig
            assign elig[gi] = validtx_i[gi] && !ack_q[gi]
                              && (cred_all[adr_i[gi*AW_DEV +: AW_DEV]] != '0);
        end
    endgenerate

    // Scan farthest-first so the entry nearest the pointer is the last to overwrite.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr_q + 2'(i);
            if (elig[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    assign win_adr = adr_i[win_idx*AW_DEV +: AW_DEV];

    always_comb begin
        ack_d = '0;
        wen_d = '0;
        dat_d = dat_q;
        ptr_d = ptr_q;
        err_d = err_q | (|ovf);
        if (win_vld) begin
            ack_d = 4'(1) << win_idx;
            wen_d = N_DEV'(1) << win_adr;
            dat_d = dat_i[win_idx*DW +: DW];
            ptr_d = win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= '0;
            wen_q <= '0;
            dat_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            wen_q <= wen_d;
            dat_q <= dat_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    // A return and an issue to the same destination cancel; a return at full credit saturates and flags.
    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : gen_cred
            logic [CW-1:0] cred_q, cred_d;

            assign ovf[gi] = credit_ret_i[gi] && !wen_d[gi] && (cred_q == CRED_MAX);

            always_comb begin
                cred_d = cred_q;
                case ({credit_ret_i[gi], wen_d[gi]})
                    2'b10:   if (cred_q != CRED_MAX) cred_d = cred_q + 1'b1;
                    2'b01:   cred_d = cred_q - 1'b1;
                    default: cred_d = cred_q;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) cred_q <= CRED_MAX;
                else        cred_q <= cred_d;
            end

            assign cred_all[gi]          = cred_q;
            assign credit_o[gi*CW +: CW] = cred_q;
        end
    endgenerate

`ifdef XBAR_SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_stats
            logic [7:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (stats_clr_i)                      cnt_d = '0;
                else if (ack_d[gi] && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign grant_cnt_o[gi*8 +: 8] = cnt_q;
        end
    endgenerate
`endif

    assign acktx_o   = ack_q;
    assign int_wen_o = wen_q;
    assign int_dat_o = dat_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_xbar_rr_sched.sv
// Scenario bench for xbar_rr_sched: expected grants are queued as stimulus is driven and checked as the DUT issues.
module tb_xbar_rr_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  validtx_i = '0;
    logic [7:0]  adr_i = '0;
    logic [15:0] dat_i = '0;
    logic [3:0]  acktx_o;
    logic [3:0]  int_wen_o;
    logic [3:0]  int_dat_o;
    logic [3:0]  credit_ret_i = '0;
    logic [11:0] credit_o;
    logic        err_o;
`ifdef XBAR_SCHED_STATS_EN
    logic        stats_clr_i = 1'b0;
    logic [31:0] grant_cnt_o;
`endif

    xbar_rr_sched dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .validtx_i    (validtx_i),
        .adr_i        (adr_i),
        .dat_i        (dat_i),
        .acktx_o      (acktx_o),
        .int_wen_o    (int_wen_o),
        .int_dat_o    (int_dat_o),
        .credit_ret_i (credit_ret_i),
        .credit_o     (credit_o),
        .err_o        (err_o)
`ifdef XBAR_SCHED_STATS_EN
        ,
        .stats_clr_i  (stats_clr_i),
        .grant_cnt_o  (grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] wen;
        logic [3:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [2:0] cred(input int d);
        return credit_o[d*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        #1;
        rst_i        = 1'b0;
        validtx_i    = '0;
        credit_ret_i = '0;
        adr_i        = '0;
        dat_i        = '0;
        repeat (2) tick();
        rst_i = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (acktx_o !== 4'b0) $display("FAIL reset_ack got=%b exp=0000", acktx_o); else n_pass++;
        n_checks++; if (int_wen_o !== 4'b0) $display("FAIL reset_wen got=%b exp=0000", int_wen_o); else n_pass++;
        n_checks++; if (int_dat_o !== 4'h0) $display("FAIL reset_dat got=%h exp=0", int_dat_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else n_pass++;
        n_checks++; if (credit_o !== {4{3'd4}}) $display("FAIL reset_credit got=%h exp=%h", credit_o, {4{3'd4}}); else n_pass++;
        $display("reset: ack=%b wen=%b dat=%h credit=%h", acktx_o, int_wen_o, int_dat_o, credit_o);
    endtask

    task automatic test_single();
        apply_reset();
        validtx_i = 4'b0001;
        adr_i     = 8'b00_00_00_10;
        dat_i     = 16'h000A;
        sb_q.push_back('{ack: 4'b0001, wen: 4'b0100, dat: 4'hA});
        tick();
        validtx_i = '0;
        e = sb_q.pop_front();
        n_checks++; if (acktx_o !== e.ack) $display("FAIL single_ack got=%b exp=%b", acktx_o, e.ack); else n_pass++;
        n_checks++; if (int_wen_o !== e.wen) $display("FAIL single_wen got=%b exp=%b", int_wen_o, e.wen); else n_pass++;
        n_checks++; if (int_dat_o !== e.dat) $display("FAIL single_dat got=%h exp=%h", int_dat_o, e.dat); else n_pass++;
        n_checks++; if (cred(2) !== 3'd3) $display("FAIL single_credit2 got=%0d exp=3", cred(2)); else n_pass++;
        $display("single: ack=%b wen=%b dat=%h credit2=%0d", acktx_o, int_wen_o, int_dat_o, cred(2));
        tick();
        n_checks++; if (acktx_o !== 4'b0) $display("FAIL single_idle_ack got=%b exp=0000", acktx_o); else n_pass++;
        n_checks++; if (int_wen_o !== 4'b0) $display("FAIL single_idle_wen got=%b exp=0000", int_wen_o); else n_pass++;
        n_checks++; if (int_dat_o !== 4'hA) $display("FAIL single_hold_dat got=%h exp=a", int_dat_o); else n_pass++;
    endtask

    task automatic test_fairness();
        int acks[4];
        apply_reset();
        acks      = '{0, 0, 0, 0};
        validtx_i = 4'hF;
        adr_i     = 8'b11_10_01_00;
        dat_i     = 16'h8765;
        for (int i = 0; i < 8; i++)
            sb_q.push_back('{ack: 4'(1 << (i % 4)), wen: 4'(1 << (i % 4)), dat: 4'(5 + i % 4)});
        for (int i = 0; i < 8; i++) begin
            tick();
            credit_ret_i = int_wen_o;
            e = sb_q.pop_front();
            n_checks++; if (acktx_o !== e.ack) $display("FAIL fair_ack[%0d] got=%b exp=%b", i, acktx_o, e.ack); else n_pass++;
            n_checks++; if (int_wen_o !== e.wen) $display("FAIL fair_wen[%0d] got=%b exp=%b", i, int_wen_o, e.wen); else n_pass++;
            n_checks++; if (int_dat_o !== e.dat) $display("FAIL fair_dat[%0d] got=%h exp=%h", i, int_dat_o, e.dat); else n_pass++;
            for (int k = 0; k < 4; k++) if (acktx_o[k] === 1'b1) acks[k]++;
            $display("fair[%0d]: ack=%b wen=%b dat=%h", i, acktx_o, int_wen_o, int_dat_o);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (acks[k] != 2) $display("FAIL fair_count[%0d] got=%0d exp=2", k, acks[k]); else n_pass++;
        end
        validtx_i = '0;
        tick();
        credit_ret_i = int_wen_o;
        tick();
        credit_ret_i = '0;
        n_checks++; if (credit_o !== {4{3'd4}}) $display("FAIL fair_credit got=%h exp=%h", credit_o, {4{3'd4}}); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL fair_err got=%b exp=0", err_o); else n_pass++;
    endtask

    task automatic test_credit_exhaust();
        int         item;
        logic [3:0] prev_dat;
        apply_reset();
        item      = 0;
        prev_dat  = 4'h0;
        validtx_i = 4'b0010;
        adr_i     = 8'b00_00_11_00;
        dat_i     = 16'h0010;
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0 && c < 8) begin
                prev_dat = 4'(1 + c / 2);
                sb_q.push_back('{ack: 4'b0010, wen: 4'b1000, dat: prev_dat});
            end else begin
                sb_q.push_back('{ack: 4'b0000, wen: 4'b0000, dat: prev_dat});
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            e = sb_q.pop_front();
            n_checks++; if (acktx_o !== e.ack) $display("FAIL exh_ack[%0d] got=%b exp=%b", c, acktx_o, e.ack); else n_pass++;
            n_checks++; if (int_wen_o !== e.wen) $display("FAIL exh_wen[%0d] got=%b exp=%b", c, int_wen_o, e.wen); else n_pass++;
            n_checks++; if (int_dat_o !== e.dat) $display("FAIL exh_dat[%0d] got=%h exp=%h", c, int_dat_o, e.dat); else n_pass++;
            if (acktx_o[1] === 1'b1 && item < 5) begin
                item++;
                dat_i[7:4] = 4'(1 + item);
            end
            $display("exh[%0d]: ack=%b wen=%b dat=%h credit3=%0d", c, acktx_o, int_wen_o, int_dat_o, cred(3));
        end
        n_checks++; if (cred(3) !== 3'd0) $display("FAIL exh_credit_zero got=%0d exp=0", cred(3)); else n_pass++;
        credit_ret_i = 4'b1000;
        tick();
        credit_ret_i = '0;
        n_checks++; if (acktx_o !== 4'b0) $display("FAIL exh_ret_ack got=%b exp=0000", acktx_o); else n_pass++;
        n_checks++; if (cred(3) !== 3'd1) $display("FAIL exh_ret_credit got=%0d exp=1", cred(3)); else n_pass++;
        tick();
        n_checks++; if (acktx_o !== 4'b0010) $display("FAIL exh_extra_ack got=%b exp=0010", acktx_o); else n_pass++;
        n_checks++; if (int_dat_o !== 4'h5) $display("FAIL exh_extra_dat got=%h exp=5", int_dat_o); else n_pass++;
        n_checks++; if (cred(3) !== 3'd0) $display("FAIL exh_extra_credit got=%0d exp=0", cred(3)); else n_pass++;
        $display("exh_extra: ack=%b dat=%h credit3=%0d", acktx_o, int_dat_o, cred(3));
        dat_i[7:4] = 4'h6;
        repeat (2) tick();
        n_checks++; if (acktx_o !== 4'b0) $display("FAIL exh_stall_ack got=%b exp=0000", acktx_o); else n_pass++;
        validtx_i = '0;
    endtask

    task automatic test_bypass();
        int n;
        apply_reset();
        n         = 0;
        validtx_i = 4'b0001;
        adr_i     = 8'b00_00_00_00;
        dat_i     = 16'h0003;
        repeat (8) begin
            tick();
            if (acktx_o[0] === 1'b1) n++;
        end
        n_checks++; if (n != 4) $display("FAIL bypass_drain_acks got=%0d exp=4", n); else n_pass++;
        n_checks++; if (cred(0) !== 3'd0) $display("FAIL bypass_credit0 got=%0d exp=0", cred(0)); else n_pass++;
        validtx_i = 4'b0101;
        adr_i     = 8'b00_01_00_00;
        dat_i     = 16'h0B03;
        sb_q.push_back('{ack: 4'b0100, wen: 4'b0010, dat: 4'hB});
        tick();
        validtx_i = 4'b0001;
        e = sb_q.pop_front();
        n_checks++; if (acktx_o !== e.ack) $display("FAIL bypass_ack got=%b exp=%b", acktx_o, e.ack); else n_pass++;
        n_checks++; if (int_wen_o !== e.wen) $display("FAIL bypass_wen got=%b exp=%b", int_wen_o, e.wen); else n_pass++;
        n_checks++; if (int_dat_o !== e.dat) $display("FAIL bypass_dat got=%h exp=%h", int_dat_o, e.dat); else n_pass++;
        n_checks++; if (cred(1) !== 3'd3) $display("FAIL bypass_credit1 got=%0d exp=3", cred(1)); else n_pass++;
        $display("bypass: ack=%b wen=%b dat=%h credit0=%0d credit1=%0d", acktx_o, int_wen_o, int_dat_o, cred(0), cred(1));
        validtx_i = '0;
    endtask

    task automatic test_credit_simul();
        apply_reset();
        validtx_i = 4'b0010;
        adr_i     = 8'b00_00_01_00;
        dat_i     = 16'h0010;
        repeat (3) tick();
        validtx_i = '0;
        n_checks++; if (cred(1) !== 3'd2) $display("FAIL simul_pre_credit1 got=%0d exp=2", cred(1)); else n_pass++;
        tick();
        validtx_i    = 4'b0010;
        dat_i        = 16'h00C0;
        credit_ret_i = 4'b0010;
        sb_q.push_back('{ack: 4'b0010, wen: 4'b0010, dat: 4'hC});
        tick();
        validtx_i    = '0;
        credit_ret_i = '0;
        e = sb_q.pop_front();
        n_checks++; if (acktx_o !== e.ack) $display("FAIL simul_ack got=%b exp=%b", acktx_o, e.ack); else n_pass++;
        n_checks++; if (int_dat_o !== e.dat) $display("FAIL simul_dat got=%h exp=%h", int_dat_o, e.dat); else n_pass++;
        n_checks++; if (cred(1) !== 3'd2) $display("FAIL simul_credit1 got=%0d exp=2", cred(1)); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL simul_err_early got=%b exp=0", err_o); else n_pass++;
        $display("simul: ack=%b dat=%h credit1=%0d err=%b", acktx_o, int_dat_o, cred(1), err_o);
        credit_ret_i = 4'b0001;
        tick();
        credit_ret_i = '0;
        n_checks++; if (err_o !== 1'b1) $display("FAIL ovf_err got=%b exp=1", err_o); else n_pass++;
        n_checks++; if (cred(0) !== 3'd4) $display("FAIL ovf_credit0 got=%0d exp=4", cred(0)); else n_pass++;
        tick();
        n_checks++; if (err_o !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", err_o); else n_pass++;
        $display("overflow: err=%b credit0=%0d", err_o, cred(0));
    endtask

    task automatic test_async_reset();
        apply_reset();
        validtx_i = 4'hF;
        adr_i     = 8'b11_10_01_00;
        dat_i     = 16'h8765;
        sb_q.push_back('{ack: 4'b0001, wen: 4'b0001, dat: 4'h5});
        tick();
        e = sb_q.pop_front();
        n_checks++; if (acktx_o !== e.ack) $display("FAIL arst_pre_ack got=%b exp=%b", acktx_o, e.ack); else n_pass++;
        n_checks++; if (int_dat_o !== e.dat) $display("FAIL arst_pre_dat got=%h exp=%h", int_dat_o, e.dat); else n_pass++;
        #3;
        rst_i = 1'b0;
        #1;
        n_checks++; if (acktx_o !== 4'b0) $display("FAIL arst_ack got=%b exp=0000", acktx_o); else n_pass++;
        n_checks++; if (int_wen_o !== 4'b0) $display("FAIL arst_wen got=%b exp=0000", int_wen_o); else n_pass++;
        n_checks++; if (int_dat_o !== 4'h0) $display("FAIL arst_dat got=%h exp=0", int_dat_o); else n_pass++;
        $display("async_reset: ack=%b wen=%b dat=%h", acktx_o, int_wen_o, int_dat_o);
        validtx_i = '0;
        tick();
        rst_i = 1'b1;
        tick();
        n_checks++; if (credit_o !== {4{3'd4}}) $display("FAIL arst_credit got=%h exp=%h", credit_o, {4{3'd4}}); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL arst_err got=%b exp=0", err_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_exhaust();
        test_bypass();
        test_credit_simul();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
